// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - AXI read channel arbiter between icache and dcache refill paths.
// Optional round-robin tie-break enabled by defining AXI_RD_ARB_RR_EN.
module axi_rd_arbiter #(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] I_ID       = 4'd0,
    parameter logic [3:0] D_ID       = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_cached,
    output logic        i_ack,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_cached,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        rd_err,
    output logic        proto_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int          OFF_BITS  = $clog2(LINE_WORDS) + 2;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t      state, state_nx;
    logic        owner_d;
    logic [31:0] addr_q;
    logic        cached_q;
    logic [7:0]  beat_cnt;
    logic        idle;
    logic        grant_i, grant_d;
    logic        beat;
    logic        beat_bad;

    assign idle = (state == IDLE);

`ifdef AXI_RD_ARB_RR_EN
    // rr_i set means the icache wins the next tie
    logic rr_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_i <= 1'b1;
        end else if (grant_i) begin
            rr_i <= 1'b0;
        end else if (grant_d) begin
            rr_i <= 1'b1;
        end
    end

    assign grant_d = idle & d_req & (~i_req | ~rr_i);
`else
    assign grant_d = idle & d_req;
`endif
    assign grant_i = idle & i_req & ~grant_d;

    assign arid    = owner_d ? D_ID : I_ID;
    assign araddr  = cached_q ? (addr_q & LINE_MASK) : addr_q;
    assign arlen   = cached_q ? 8'(LINE_WORDS - 1) : 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign beat = (state == R) & rvalid;
    // Short burst shows as rlast before arlen; overrun shows as a non-last beat at/after arlen
    assign beat_bad = (rid != arid) | (rlast ? (beat_cnt != arlen) : (beat_cnt >= arlen));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b1;
            addr_q    <= '0;
            cached_q  <= 1'b0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_i | grant_d) begin
                owner_d  <= grant_d;
                addr_q   <= grant_d ? d_addr : i_addr;
                cached_q <= grant_d ? d_cached : i_cached;
            end
            if ((state == AR) && arready) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (beat && beat_bad) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        arvalid  = 1'b0;
        rready   = 1'b0;
        i_ack    = grant_i;
        d_ack    = grant_d;
        case (state)
            IDLE: if (i_req | d_req) state_nx = AR;
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nx = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid && rlast) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign i_rvalid = beat & ~owner_d;
    assign d_rvalid = beat & owner_d;
    assign i_rdata  = i_rvalid ? rdata : '0;
    assign d_rdata  = d_rvalid ? rdata : '0;
    assign i_rlast  = i_rvalid & rlast;
    assign d_rlast  = d_rvalid & rlast;
    assign rd_err   = beat & (rresp != 2'b00);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - Self-checking bench for axi_rd_arbiter with directed and randomized transactions.
module tb_axi_rd_arbiter;

    localparam int LINE_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0;
    logic        i_cached = 1'b0, d_cached = 1'b0;
    logic        i_ack, d_ack, i_rvalid, d_rvalid, i_rlast, d_rlast;
    logic [31:0] i_rdata, d_rdata;
    logic        rd_err, proto_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;
    bit last_d;

    axi_rd_arbiter #(.LINE_WORDS(LINE_WORDS), .I_ID(4'd0), .D_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_cached(i_cached), .i_ack(i_ack),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .d_req(d_req), .d_addr(d_addr), .d_cached(d_cached), .d_ack(d_ack),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .rd_err(rd_err), .proto_err(proto_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Reference arbitration: dcache priority, or alternate on a tie when round-robin is built in
    function automatic bit pick_d(input bit ir, input bit dr);
`ifdef AXI_RD_ARB_RR_EN
        if (ir && dr) return !last_d;
`endif
        return dr;
    endfunction

    task automatic grant_check(input bit exp_d);
        chk("i_ack", 32'(i_ack), 32'(!exp_d));
        chk("d_ack", 32'(d_ack), 32'(exp_d));
        last_d = exp_d;
    endtask

    task automatic ar_phase(input bit own_d, input logic [31:0] addr, input bit cached,
                            input int wait_n, input bit keep_i, input bit keep_d);
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        exp_addr = cached ? addr - (addr % (LINE_WORDS * 4)) : addr;
        exp_len  = cached ? 8'(LINE_WORDS - 1) : 8'd0;
        cyc;
        i_req = i_req & keep_i;
        d_req = d_req & keep_d;
        for (int k = 0; k <= wait_n; k++) begin
            arready = (k == wait_n);
            settle;
            chk("arvalid", 32'(arvalid), 32'd1);
            chk("araddr", araddr, exp_addr);
            chk("arlen", 32'(arlen), 32'(exp_len));
            chk("arid", 32'(arid), own_d ? 32'd1 : 32'd0);
            chk("arsize_arburst", {27'd0, arsize, arburst}, {27'd0, 3'b010, 2'b01});
            chk("ack_busy", 32'({i_ack, d_ack}), 32'd0);
            cyc;
        end
        arready = 1'b0;
    endtask

    task automatic r_phase(input bit own_d, input int nbeats, input logic [31:0] base,
                           input int err_beat, input int gap_max);
        int g;
        for (int b = 0; b < nbeats; b++) begin
            g = $urandom_range(0, gap_max);
            repeat (g) begin
                rvalid = 1'b0;
                settle;
                chk("gap_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
                chk("gap_rready", 32'(rready), 32'd1);
                cyc;
            end
            rvalid = 1'b1;
            rid    = own_d ? 4'd1 : 4'd0;
            rdata  = base + 32'(b);
            rlast  = (b == nbeats - 1);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            settle;
            chk("own_rvalid", 32'(own_d ? d_rvalid : i_rvalid), 32'd1);
            chk("own_rdata", own_d ? d_rdata : i_rdata, base + 32'(b));
            chk("own_rlast", 32'(own_d ? d_rlast : i_rlast), 32'(b == nbeats - 1));
            chk("other_rvalid", 32'(own_d ? i_rvalid : d_rvalid), 32'd0);
            chk("rd_err", 32'(rd_err), 32'(b == err_beat));
            chk("ack_in_r", 32'({i_ack, d_ack}), 32'd0);
            cyc;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        settle;
        chk("idle_arvalid", 32'(arvalid), 32'd0);
        chk("idle_rready", 32'(rready), 32'd0);
    endtask

    initial begin
        bit          ir, dr, ic, dc, wd;
        logic [31:0] ia, da;
        int          nb;

        // Reset state
        rst = 1'b1;
        cyc;
        cyc;
        settle;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        rst    = 1'b0;
        last_d = 1'b1;
        cyc;

        // Uncached dcache load, arready held off 5 cycles
        d_req = 1'b1; d_addr = 32'hBFAF_8004; d_cached = 1'b0;
        settle;
        grant_check(1'b1);
        ar_phase(1'b1, 32'hBFAF_8004, 1'b0, 5, 1'b0, 1'b0);
        r_phase(1'b1, 1, 32'h0000_5555, -1, 0);

        // Cached icache refill: 0x1C00_0014 aligns to 0x1C00_0010, beats A0..A3
        cyc;
        i_req = 1'b1; i_addr = 32'h1C00_0014; i_cached = 1'b1;
        settle;
        grant_check(1'b0);
        ar_phase(1'b0, 32'h1C00_0014, 1'b1, 0, 1'b0, 1'b0);
        r_phase(1'b0, LINE_WORDS, 32'h0000_00A0, -1, 0);

        // Simultaneous requests: dcache first, icache waits until after its rlast
        cyc;
        i_req = 1'b1; i_addr = 32'h0000_1000; i_cached = 1'b1;
        d_req = 1'b1; d_addr = 32'h0000_2008; d_cached = 1'b0;
        settle;
        grant_check(1'b1);
        ar_phase(1'b1, 32'h0000_2008, 1'b0, 1, 1'b1, 1'b0);
        r_phase(1'b1, 1, 32'h0000_0D00, -1, 1);
        chk("i_ack_after_d", 32'(i_ack), 32'd1);
        last_d = 1'b0;
        ar_phase(1'b0, 32'h0000_1000, 1'b1, 0, 1'b0, 1'b0);
        r_phase(1'b0, LINE_WORDS, 32'h0000_1100, -1, 0);

        // Both held across three grants: model decides the order
        cyc;
        i_req = 1'b1; d_req = 1'b1; d_cached = 1'b0; i_cached = 1'b0;
        for (int t = 0; t < 3; t++) begin
            settle;
            wd = pick_d(1'b1, 1'b1);
            grant_check(wd);
            ar_phase(wd, wd ? d_addr : i_addr, 1'b0, 0, 1'b1, 1'b1);
            r_phase(wd, 1, 32'h0000_3000 + 32'(t), -1, 0);
        end
        i_req = 1'b0; d_req = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            cyc;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            ia = $urandom; da = $urandom;
            ic = 1'($urandom_range(0, 1));
            dc = 1'($urandom_range(0, 1));
            i_req = ir; i_addr = ia; i_cached = ic;
            d_req = dr; d_addr = da; d_cached = dc;
            settle;
            wd = pick_d(ir, dr);
            grant_check(wd);
            nb = (wd ? dc : ic) ? LINE_WORDS : 1;
            ar_phase(wd, wd ? da : ia, wd ? dc : ic, $urandom_range(0, 3), 1'b0, 1'b0);
            r_phase(wd, nb, $urandom, $urandom_range(0, nb), 2);
        end
        chk("no_proto_err", 32'(proto_err), 32'd0);

        // Short cached burst sets sticky proto_err
        cyc;
        i_req = 1'b1; i_addr = 32'h0000_4000; i_cached = 1'b1;
        settle;
        grant_check(1'b0);
        ar_phase(1'b0, 32'h0000_4000, 1'b1, 0, 1'b0, 1'b0);
        r_phase(1'b0, 2, 32'h0000_4400, -1, 0);
        chk("proto_err_set", 32'(proto_err), 32'd1);
        cyc;
        d_req = 1'b1; d_addr = 32'h0000_5004; d_cached = 1'b0;
        settle;
        grant_check(1'b1);
        ar_phase(1'b1, 32'h0000_5004, 1'b0, 0, 1'b0, 1'b0);
        r_phase(1'b1, 1, 32'h0000_5500, -1, 0);
        chk("proto_err_sticky", 32'(proto_err), 32'd1);

        // Reset mid-burst after first beat
        cyc;
        i_req = 1'b1; i_addr = 32'h0000_6000; i_cached = 1'b1;
        settle;
        grant_check(1'b0);
        ar_phase(1'b0, 32'h0000_6000, 1'b1, 0, 1'b0, 1'b0);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_6600; rlast = 1'b0; rresp = 2'b00;
        settle;
        chk("mid_beat1", 32'(i_rvalid), 32'd1);
        cyc;
        rvalid = 1'b0;
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        last_d = 1'b1;
        settle;
        chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
        chk("mid_rst_rready", 32'(rready), 32'd0);
        chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
        i_req = 1'b1; i_addr = 32'h0000_7010; i_cached = 1'b0;
        settle;
        grant_check(1'b0);
        ar_phase(1'b0, 32'h0000_7010, 1'b0, 0, 1'b0, 1'b0);
        r_phase(1'b0, 1, 32'h0000_7700, 0, 0);
        chk("post_rst_proto_err", 32'(proto_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
